// File: rtl/bootrom_pkg.sv
// Shared types and helpers for the boot memory controller.
package bootrom_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE  = 2'd0;
    localparam err_code_t ERR_RANGE = 2'd1;
    localparam err_code_t ERR_WPROT = 2'd2;

    // Counter is wide enough for the largest supported latency (255).
    localparam int CNT_W = 8;

    // Number of address bits that select a byte within a word of width_bits.
    function automatic int byte_off(input int width_bits);
        return $clog2(width_bits / 8);
    endfunction

endpackage

// File: rtl/bootrom_bram.sv
// Single-port block RAM with per-byte write enables and a registered read port.
module bootrom_bram #(
  parameter int DATA_WIDTH = 128,
  parameter int LINES      = 4096,
  parameter     INIT_FILE  = "bootrom.hex"
) (
  input  logic                      clk,
  input  logic                      en_i,
  input  logic [DATA_WIDTH/8-1:0]   we_i,
  input  logic [$clog2(LINES)-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic [DATA_WIDTH-1:0]     rdata_o
);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [0:LINES-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (we_i[b]) begin
          mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bootrom_ctrl.sv
// Boot memory controller: one outstanding ready/valid transaction against a block RAM,
// fixed programmable response latency, beat-selected read data and byte-masked writes.
module bootrom_ctrl
    import bootrom_pkg::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int RESP_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 24,
    parameter int MEM_BYTES    = 65536,
    parameter int READ_LATENCY = 4,
    parameter int WRITE_EN     = 1,
    parameter     INIT_FILE    = "bootrom.hex"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_we_i,
    input  logic [RESP_WIDTH/8-1:0] req_be_i,
    input  logic [RESP_WIDTH-1:0]   req_wdata_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [RESP_WIDTH-1:0]   resp_data_o,
    output logic                    resp_err_o
);

    localparam int LINE_OFF   = byte_off(DATA_WIDTH);
    localparam int BEAT_OFF   = byte_off(RESP_WIDTH);
    localparam int LINES      = MEM_BYTES * 8 / DATA_WIDTH;
    localparam int IDX_W      = $clog2(LINES);
    localparam int NBEATS     = DATA_WIDTH / RESP_WIDTH;
    localparam int BEAT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LANE_BYTES = RESP_WIDTH / 8;
    localparam int LINE_BYTES = DATA_WIDTH / 8;

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RESP_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                    resp_err_q, resp_err_d;

    logic [IDX_W-1:0]        idx_q;
    logic [BEAT_W-1:0]       beat_q;
    logic                    we_q;
    logic [LANE_BYTES-1:0]   be_q;
    logic [RESP_WIDTH-1:0]   wdata_q;
    err_code_t               err_q, err_d;

    logic                    accept;
    logic                    bram_en;
    logic [LINE_BYTES-1:0]   bram_we;
    logic [DATA_WIDTH-1:0]   bram_wdata;
    logic [DATA_WIDTH-1:0]   bram_rdata;
    logic [RESP_WIDTH-1:0]   rd_beat;

    assign req_ready_o  = (state_q == IDLE) && !rst;
    assign accept       = req_valid_i && req_ready_o;
    assign resp_valid_o = (state_q == RESP);
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;

    always_comb begin
        err_d = ERR_NONE;
        if ({1'b0, req_addr_i} >= ADDR_LIMIT) begin
            err_d = ERR_RANGE;
        end else if (req_we_i && (WRITE_EN == 0)) begin
            err_d = ERR_WPROT;
        end
    end

    // Request fields are plain data registers; only the FSM and response are reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= IDX_W'(req_addr_i >> LINE_OFF);
            beat_q  <= BEAT_W'((req_addr_i >> BEAT_OFF) & ADDR_WIDTH'(NBEATS - 1));
            we_q    <= req_we_i;
            be_q    <= req_be_i;
            wdata_q <= req_wdata_i;
            err_q   <= err_d;
        end
    end

    // The RAM is touched once, in the first BUSY cycle; errored requests never reach it.
    assign bram_en    = (state_q == BUSY) && (cnt_q == '0) && (err_q == ERR_NONE);
    assign bram_we    = we_q ? (LINE_BYTES'(be_q) << (int'(beat_q) * LANE_BYTES)) : '0;
    assign bram_wdata = {NBEATS{wdata_q}};
    assign rd_beat    = bram_rdata[int'(beat_q) * RESP_WIDTH +: RESP_WIDTH];

    bootrom_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINES      (LINES),
        .INIT_FILE  (INIT_FILE)
    ) u_bram (
        .clk     (clk),
        .en_i    (bram_en),
        .we_i    (bram_we),
        .addr_i  (idx_q),
        .wdata_i (bram_wdata),
        .rdata_o (bram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    resp_err_d  = (err_q != ERR_NONE);
                    resp_data_d = ((err_q != ERR_NONE) || we_q) ? '0 : rd_beat;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d     = IDLE;
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_bootrom_ctrl.sv
// Scoreboard bench for bootrom_ctrl: default build, a write-protected build and a 64b/latency-2 build.
module tb_bootrom_ctrl;

    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [ND-1:0]        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [ND-1:0][23:0]  req_addr;
    logic [ND-1:0][7:0]   req_be;
    logic [ND-1:0][63:0]  req_wdata, resp_data;

    typedef struct {
        logic [63:0] data;
        logic        err;
        bit          known;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [int];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_data;

    always #5 clk = ~clk;

    bootrom_ctrl #(.INIT_FILE("")) dut0 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
        .req_we_i(req_we[0]), .req_be_i(req_be[0]), .req_wdata_i(req_wdata[0]),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
        .resp_data_o(resp_data[0]), .resp_err_o(resp_err[0])
    );

    bootrom_ctrl #(.WRITE_EN(0), .INIT_FILE("")) dut1 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
        .req_we_i(req_we[1]), .req_be_i(req_be[1]), .req_wdata_i(req_wdata[1]),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
        .resp_data_o(resp_data[1]), .resp_err_o(resp_err[1])
    );

    bootrom_ctrl #(.DATA_WIDTH(64), .RESP_WIDTH(64), .READ_LATENCY(2), .INIT_FILE("")) dut2 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]), .req_addr_i(req_addr[2]),
        .req_we_i(req_we[2]), .req_be_i(req_be[2]), .req_wdata_i(req_wdata[2]),
        .resp_valid_o(resp_valid[2]), .resp_ready_i(resp_ready[2]),
        .resp_data_o(resp_data[2]), .resp_err_o(resp_err[2])
    );

    function automatic int mkey(input int d, input logic [23:0] addr);
        return d * (1 << 22) + int'(addr >> 3);
    endfunction

    // Waits for req_ready, drives one request, pushes its expected response. Returns at the
    // negedge following the acceptance edge.
    task automatic issue(input int d, input logic [23:0] addr, input logic we,
                         input logic [7:0] be, input logic [63:0] wdata, input bit known,
                         output int waited);
        exp_t        e;
        int          w;
        int          key;
        logic [63:0] tmp;
        w   = 0;
        key = mkey(d, addr);
        e.err   = (addr >= 24'h01_0000) || (we && d == 1);
        e.known = known;
        e.data  = '0;
        if (!e.err) begin
            tmp = model.exists(key) ? model[key] : 64'h0;
            if (we) begin
                for (int b = 0; b < 8; b++) begin
                    if (be[b]) tmp[b*8 +: 8] = wdata[b*8 +: 8];
                end
                model[key] = tmp;
            end else begin
                e.data = tmp;
            end
        end
        while (req_ready[d] !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready dut%0d: req_ready=%b required 1", d, req_ready[d]);
        end
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        req_we[d]    = we;
        req_be[d]    = be;
        req_wdata[d] = wdata;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = 24'($urandom);
        req_we[d]    = 1'($urandom);
        req_wdata[d] = {$urandom, $urandom};
        waited = w;
    endtask

    // Waits for the response, checks latency and contents against the scoreboard, optionally
    // holds resp_ready low for 'hold' cycles, then completes the handshake.
    task automatic collect(input int d, input int lat, input int hold, output int ready_edges);
        exp_t e;
        int   n;
        n = 0;
        while (resp_valid[d] !== 1'b1 && n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL latency dut%0d: %0d edges, required %0d", d, n, lat);
        end
        if (resp_valid[d] !== 1'b1) begin
            if (sb.size() > 0) e = sb.pop_front();
            ready_edges = -1;
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard dut%0d: response with nothing outstanding, required none", d);
            ready_edges = -1;
            return;
        end
        e = sb.pop_front();
        checks++;
        if (resp_err[d] !== e.err) begin
            errors++;
            $display("FAIL resp_err dut%0d: %b, required %b", d, resp_err[d], e.err);
        end
        if (e.known) begin
            checks++;
            if (resp_data[d] !== e.data) begin
                errors++;
                $display("FAIL resp_data dut%0d: %h, required %h", d, resp_data[d], e.data);
            end
        end
        last_data = resp_data[d];
        for (int i = 0; i < hold; i++) begin
            req_valid[d] = (i % 2 == 1);
            req_addr[d]  = 24'h18;
            req_we[d]    = 1'b1;
            req_be[d]    = 8'hFF;
            req_wdata[d] = '1;
            @(posedge clk);
            n++;
            @(negedge clk);
            checks++;
            if (resp_valid[d] !== 1'b1 || resp_data[d] !== e.data || resp_err[d] !== e.err
                || req_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable dut%0d cyc%0d: v=%b d=%h e=%b rdy=%b, required v=1 d=%h e=%b rdy=0",
                         d, i, resp_valid[d], resp_data[d], resp_err[d], req_ready[d], e.data, e.err);
            end
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(posedge clk);
        n++;
        @(negedge clk);
        checks++;
        if (resp_valid[d] !== 1'b0) begin
            errors++;
            $display("FAIL resp_one_cycle dut%0d: resp_valid=%b after handshake, required 0", d, resp_valid[d]);
        end
        while (req_ready[d] !== 1'b1 && n < 600) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        ready_edges = n;
    endtask

    task automatic txn(input int d, input logic [23:0] addr, input logic we, input logic [7:0] be,
                       input logic [63:0] wdata, input int lat, output int ready_edges);
        int w;
        issue(d, addr, we, be, wdata, 1'b1, w);
        collect(d, lat, 0, ready_edges);
    endtask

    task automatic check_idle_outputs(input int d, input string tag, input logic ready_exp);
        checks++;
        if (req_ready[d] !== ready_exp || resp_valid[d] !== 1'b0 || resp_err[d] !== 1'b0
            || resp_data[d] !== 64'h0) begin
            errors++;
            $display("FAIL %s dut%0d: rdy=%b v=%b e=%b d=%h, required rdy=%b v=0 e=0 d=0",
                     tag, d, req_ready[d], resp_valid[d], resp_err[d], resp_data[d], ready_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) check_idle_outputs(d, "reset_state", 1'b0);
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) check_idle_outputs(d, "after_reset", 1'b1);
    endtask

    task automatic preload();
        int r;
        for (int i = 0; i < 8; i++) txn(0, 24'(i * 8), 1'b1, 8'hFF, {$urandom, $urandom}, 4, r);
        for (int i = 0; i < 4; i++) txn(2, 24'(i * 8), 1'b1, 8'hFF, {$urandom, $urandom}, 2, r);
    endtask

    task automatic test_read_basic();
        int r;
        txn(0, 24'h000008, 1'b0, 8'h00, 64'h0, 4, r);
        txn(0, 24'h000000, 1'b0, 8'h00, 64'h0, 4, r);
        txn(0, 24'h000038, 1'b0, 8'h00, 64'h0, 4, r);
        txn(0, 24'h00000C, 1'b0, 8'h00, 64'h0, 4, r);
        txn(0, 24'h00002F, 1'b0, 8'h00, 64'h0, 4, r);
    endtask

    task automatic test_write_merge();
        int r;
        txn(0, 24'h000010, 1'b1, 8'h0F, 64'hDEADBEEF_CAFEF00D, 4, r);
        txn(0, 24'h000010, 1'b0, 8'h00, 64'h0, 4, r);
        txn(0, 24'h000018, 1'b1, 8'hF0, 64'h12345678_9ABCDEF0, 4, r);
        txn(0, 24'h000018, 1'b0, 8'h00, 64'h0, 4, r);
        txn(0, 24'h000010, 1'b0, 8'h00, 64'h0, 4, r);
        txn(2, 24'h000008, 1'b1, 8'h3C, 64'hA5A5A5A5_5A5A5A5A, 2, r);
        txn(2, 24'h000008, 1'b0, 8'h00, 64'h0, 2, r);
    endtask

    task automatic test_range_error();
        int r;
        txn(0, 24'h010000, 1'b0, 8'h00, 64'h0, 4, r);
        txn(0, 24'h010000, 1'b1, 8'hFF, 64'hFFFF0000_FFFF0000, 4, r);
        txn(0, 24'h000000, 1'b0, 8'h00, 64'h0, 4, r);
        txn(0, 24'hFFFFF8, 1'b0, 8'h00, 64'h0, 4, r);
        txn(2, 24'h010008, 1'b0, 8'h00, 64'h0, 2, r);
    endtask

    task automatic test_write_protect();
        int w, r;
        issue(1, 24'h000000, 1'b0, 8'h00, 64'h0, 1'b0, w);
        collect(1, 4, 0, r);
        model[mkey(1, 24'h0)] = last_data;
        txn(1, 24'h000000, 1'b1, 8'hFF, ~last_data, 4, r);
        txn(1, 24'h000000, 1'b1, 8'h0F, 64'hDEADBEEF_CAFEF00D, 4, r);
        txn(1, 24'h000000, 1'b0, 8'h00, 64'h0, 4, r);
        txn(1, 24'h010000, 1'b0, 8'h00, 64'h0, 4, r);
    endtask

    task automatic test_backpressure();
        int w, r;
        resp_ready[0] = 1'b0;
        issue(0, 24'h000028, 1'b0, 8'h00, 64'h0, 1'b1, w);
        collect(0, 4, 10, r);
        checks++;
        if (r != 15) begin
            errors++;
            $display("FAIL bp_ready_edges: %0d, required 15", r);
        end
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs(0, "bp_no_extra_resp", 1'b1);
        end
        txn(0, 24'h000018, 1'b0, 8'h00, 64'h0, 4, r);
    endtask

    task automatic test_reset_abort();
        int w, r, n;
        exp_t e;
        issue(0, 24'h000008, 1'b0, 8'h00, 64'h0, 1'b1, w);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check_idle_outputs(0, "abort_busy", 1'b0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs(0, "abort_busy_release", 1'b1);
        txn(0, 24'h000008, 1'b0, 8'h00, 64'h0, 4, r);

        resp_ready[0] = 1'b0;
        issue(0, 24'h000010, 1'b0, 8'h00, 64'h0, 1'b1, w);
        e = sb[0];
        n = 0;
        while (resp_valid[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (resp_valid[0] !== 1'b1 || resp_data[0] !== e.data) begin
            errors++;
            $display("FAIL abort_resp_pending: v=%b d=%h, required v=1 d=%h", resp_valid[0], resp_data[0], e.data);
        end
        rst = 1'b1;
        #1;
        check_idle_outputs(0, "abort_resp", 1'b0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        resp_ready[0] = 1'b1;
        #1;
        check_idle_outputs(0, "abort_resp_release", 1'b1);
        txn(0, 24'h000008, 1'b0, 8'h00, 64'h0, 4, r);
    endtask

    task automatic test_back_to_back();
        int w, r;
        txn(2, 24'h000008, 1'b0, 8'h00, 64'h0, 2, r);
        checks++;
        if (r != 3) begin
            errors++;
            $display("FAIL b2b_period dut2: %0d cycles, required 3", r);
        end
        issue(2, 24'h000000, 1'b0, 8'h00, 64'h0, 1'b1, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL b2b_wait dut2: waited %0d cycles, required 0", w);
        end
        collect(2, 2, 0, r);
        txn(2, 24'h000018, 1'b0, 8'h00, 64'h0, 2, r);
        txn(0, 24'h000020, 1'b0, 8'h00, 64'h0, 4, r);
        checks++;
        if (r != 5) begin
            errors++;
            $display("FAIL b2b_period dut0: %0d cycles, required 5", r);
        end
    endtask

    initial begin
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_be     = '0;
        req_wdata  = '0;
        resp_ready = '1;
        test_reset();
        preload();
        test_read_basic();
        test_write_merge();
        test_range_error();
        test_write_protect();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before completion, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
